press_classifier: RTL and testbench

- Upstream input-conditioning stage for the pause/start control FSM of the down-counter display design.
- Synchronizes and debounces a raw push-button, then classifies each press as short or long.
- Emits single-cycle pulses: short_pulse drives pause/resume; long_pulse drives counter reload.
- Replaces the separate debounce and one-pulse pair with one tick-enabled block running on the system clock.

---
 rtl/press_classifier.sv | 151 +++++++++++++++
 tb/tb_press_classifier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// press_classifier: synchronizes and debounces a raw push-button, then
// classifies each press as short or long and emits single-cycle pulses.
//
// Parameters:
//   DB_LEN     - consecutive agreeing tick samples to change the debounced level (>= 2)
//   LONG_TICKS - ticks of continuous debounced-high that make a press "long"
//   CNT_W      - hold-counter width, 2**CNT_W must exceed LONG_TICKS
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   tick        in   one-clk sample-enable strobe for debounce and hold timing
//   pb_in       in   raw asynchronous push-button, active-high
//   pb_level    out  debounced button level
//   short_pulse out  one-clk pulse on release of a press shorter than LONG_TICKS
//   long_pulse  out  one-clk pulse when a hold reaches LONG_TICKS
//   held        out  high while the classifier is in the long-held state
module press_classifier #(
  parameter int unsigned DB_LEN     = 4,
  parameter int unsigned LONG_TICKS = 200,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb_in,
  output logic pb_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic held
);

  // Hold count at which the next tick declares a long press.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LONG_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } state_e;

  logic              sync1_q;
  logic              sync2_q;
  logic [DB_LEN-1:0] shift_q;
  logic [DB_LEN-1:0] shift_d;
  logic              pb_level_q;
  logic              lvl_q;
  logic              rise;
  logic              fall;
  state_e            state_q;
  logic [CNT_W-1:0]  hold_cnt_q;
  logic              short_q;
  logic              long_q;
  logic              held_q;

  // Two-flop synchronizer for the asynchronous button, runs every clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
    end
  end

  // Newest synchronized sample enters at the LSB.
  assign shift_d = {shift_q[DB_LEN-2:0], sync2_q};

  // Debounce: level only changes once the whole window agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      pb_level_q <= 1'b0;
    end else if (tick) begin
      shift_q <= shift_d;
      if (&shift_d) begin
        pb_level_q <= 1'b1;
      end else if (~|shift_d) begin
        pb_level_q <= 1'b0;
      end
    end
  end

  // One-clk delayed level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= pb_level_q;
    end
  end

  assign rise = pb_level_q & ~lvl_q;
  assign fall = ~pb_level_q & lvl_q;

  // Press classifier FSM with registered pulse and held outputs.
  // A release seen on the same edge as the long threshold wins, so a
  // press produces either a short pulse or a long pulse, never both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q    <= S_PRESSED;
            hold_cnt_q <= '0;
          end
        end
        S_PRESSED: begin
          if (fall) begin
            short_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (tick) begin
            if (hold_cnt_q == LAST_CNT) begin
              long_q  <= 1'b1;
              held_q  <= 1'b1;
              state_q <= S_LONG_HELD;
            end else begin
              hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
          end
        end
        S_LONG_HELD: begin
          // Counter stays saturated here; ticks cannot re-fire long_pulse.
          if (fall) begin
            held_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          held_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pb_level    = pb_level_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign held        = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with DB_LEN=4, LONG_TICKS=8.
// Edge k of a scenario is the k-th rising clk edge after its inputs are
// first applied; outputs are sampled 1 time unit after each edge and
// compared as {pb_level, short_pulse, long_pulse, held}.
module tb_press_classifier;

  logic clk;
  logic rst;
  logic tick;
  logic pb_in;
  logic pb_level;
  logic short_pulse;
  logic long_pulse;
  logic held;

  int unsigned passed;
  int unsigned total;

  press_classifier #(
    .DB_LEN    (4),
    .LONG_TICKS(8),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .pb_in      (pb_in),
    .pb_level   (pb_level),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rst held 3 edges with the button pressed, then a 6-edge press.
  task automatic test_reset();
    logic [3:0] obs;
    logic [3:0] exp;
    rst   = 1'b1;
    pb_in = 1'b1;
    tick  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = 4'b0000;
      total++;
      if (obs !== exp) $display("FAIL reset edge %0d: got %b expected %b", k, obs, exp);
      else passed++;
    end
    rst = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      pb_in = (r <= 6);
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = {(r >= 6 && r <= 11), (r == 13), 1'b0, 1'b0};
      total++;
      if (obs !== exp) $display("FAIL post_reset edge %0d: got %b expected %b", r, obs, exp);
      else passed++;
    end
  endtask

  // Button high for edges 1..n from idle with tick every cycle.
  // Level is high on edges 6..n+5; release seen at n+7; long threshold at 15.
  task automatic do_press(input int n);
    logic [3:0] obs;
    logic [3:0] exp;
    logic       e_lvl;
    logic       e_sp;
    logic       e_lp;
    logic       e_hd;
    tick = 1'b1;
    for (int k = 1; k <= n + 12; k++) begin
      pb_in = (k <= n);
      step();
      e_lvl = (k >= 6 && k <= n + 5);
      if (n <= 8) begin
        e_sp = (k == n + 7);
        e_lp = 1'b0;
        e_hd = 1'b0;
      end else begin
        e_sp = 1'b0;
        e_lp = (k == 15);
        e_hd = (k >= 15 && k <= n + 6);
      end
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = {e_lvl, e_sp, e_lp, e_hd};
      total++;
      if (obs !== exp) $display("FAIL press_%0d edge %0d: got %b expected %b", n, k, obs, exp);
      else passed++;
    end
  endtask

  // n=8 puts the release on the same edge as the long threshold.
  task automatic test_short_press();
    do_press(6);
    do_press(8);
  endtask

  // n=9 is the shortest long press; n=30 is a long hold.
  task automatic test_long_press();
    do_press(9);
    do_press(30);
  endtask

  task automatic test_bounce();
    logic [3:0] obs;
    logic [3:0] exp;
    tick = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      pb_in = (k <= 5) && (k % 2 == 1);
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = 4'b0000;
      total++;
      if (obs !== exp) $display("FAIL bounce edge %0d: got %b expected %b", k, obs, exp);
      else passed++;
    end
  endtask

  // tick on every 5th edge; the debouncer samples the button 2 edges late.
  task automatic test_tick_gating();
    logic [3:0] obs;
    logic [3:0] exp;
    for (int k = 1; k <= 25; k++) begin
      tick  = (k % 5 == 0);
      pb_in = (k <= 12);
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = 4'b0000;
      total++;
      if (obs !== exp) $display("FAIL tick_short edge %0d: got %b expected %b", k, obs, exp);
      else passed++;
    end
    tick  = 1'b1;
    pb_in = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    for (int k = 1; k <= 50; k++) begin
      tick  = (k % 5 == 0);
      pb_in = (k <= 25);
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = {(k >= 20 && k <= 44), (k == 46), 1'b0, 1'b0};
      total++;
      if (obs !== exp) $display("FAIL tick_long edge %0d: got %b expected %b", k, obs, exp);
      else passed++;
    end
    tick = 1'b1;
  endtask

  // rst on edge 13 while PRESSED with hold count 5 and the button still down.
  task automatic test_reset_mid_press();
    logic [3:0] obs;
    logic [3:0] exp;
    tick = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      pb_in = (k <= 30);
      rst   = (k == 13);
      step();
      obs = {pb_level, short_pulse, long_pulse, held};
      exp = {((k >= 6 && k <= 12) || (k >= 19 && k <= 35)), 1'b0, (k == 28),
             (k >= 28 && k <= 36)};
      total++;
      if (obs !== exp) $display("FAIL reset_mid edge %0d: got %b expected %b", k, obs, exp);
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    tick   = 1'b1;
    pb_in  = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_bounce();
    test_tick_gating();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
